// File: rtl/kyber_pkg.sv
// Purpose: shared Kyber constants and the add/sub sequencer state encoding.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package kyber_pkg;

   localparam int COEF_W         = 12;
   localparam int COEFS_PER_WORD = 8;
   localparam int WORD_W         = COEF_W * COEFS_PER_WORD;  // 96-bit RAM word
   localparam int ADDR_W         = 8;
   localparam int WORDS_PER_POLY = 256 / COEFS_PER_WORD;     // 32 words per polynomial
   localparam int K_MAX          = 4;                        // Kyber-1024

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      RUN,
      GAP,
      DONE
   } ctrl_state_t;

   // A vector command is legal for 1..kmax polynomials.
   function automatic logic k_is_legal(input logic [2:0] k, input int kmax);
      return (k != 3'd0) && (int'({1'b0, k}) <= kmax);
   endfunction

endpackage

// File: rtl/wen_counter.sv
// Purpose: counts RAM write strobes of the current job; flags the strobe that completes it.
// Latency: count updates one cycle after inc; tc is combinational on the completing strobe.
// Backpressure: none; the owner clears it synchronously before each job.
module wen_counter #(
   parameter int TERM = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam int CW = $clog2(TERM) + 1;

   logic [CW-1:0] count;

   // Strobe counter with synchronous clear; reset and clear both return to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   // Asserted on the strobe that brings the count up to TERM.
   assign tc = inc && (count == CW'(TERM - 1));

endmodule

// File: rtl/polyvec_addsub_ctrl.sv
// Purpose: sequences one K-polynomial add/sub command into K per-polynomial jobs on the add/sub unit.
// Latency: as_start one cycle after accept; done one cycle after the final job's last RAM write.
// Backpressure: cmd_ready only in IDLE; optional RUN watchdog enabled by macro ADDSUB_WATCHDOG_EN.
module polyvec_addsub_ctrl #(
   parameter int ADDR_W         = kyber_pkg::ADDR_W,
   parameter int WORDS_PER_POLY = kyber_pkg::WORDS_PER_POLY,
   parameter int K_MAX          = kyber_pkg::K_MAX,
`ifdef ADDSUB_WATCHDOG_EN
   parameter int WDOG_CYCLES    = 255,
`endif
   parameter int GAP_CYCLES     = 2        // must be >= 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_add,
   input  logic [2:0]        cmd_k,
   input  logic [ADDR_W-1:0] cmd_base_a,
   input  logic [ADDR_W-1:0] cmd_base_b,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              as_start,
   output logic              as_add_flag,
   output logic [ADDR_W-1:0] as_offset_a,
   output logic [ADDR_W-1:0] as_offset_b,
   input  logic              as_wen
);

   import kyber_pkg::*;

   localparam int GW = $clog2(GAP_CYCLES + 1);

   ctrl_state_t       state, state_nx;
   logic              accept, legal;
   logic              add_q;
   logic [2:0]        k_q, j_q;
   logic [ADDR_W-1:0] off_a_q, off_b_q;
   logic [GW-1:0]     gap_q;
   logic              err_q;
   logic              cnt_clr, cnt_inc, cnt_tc;
   logic              wdog_fire;
   logic              next_job;

   assign accept   = cmd_valid && cmd_ready;
   assign legal    = k_is_legal(cmd_k, K_MAX);
   // Strobes outside RUN (including one coinciding with ISSUE) are not counted.
   assign cnt_clr  = (state == ISSUE);
   assign cnt_inc  = (state == RUN) && as_wen;
   assign next_job = (state == GAP) && (state_nx == ISSUE);

   wen_counter #(
      .TERM (WORDS_PER_POLY)
   ) u_wen_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .tc  (cnt_tc)
   );

`ifdef ADDSUB_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wd_q;

   // Cycles since the last strobe in RUN; reloads on every strobe and outside RUN.
   always_ff @(posedge clk) begin
      if (rst || (state != RUN) || as_wen) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + WW'(1);
      end
   end

   // Fires in the WDOG_CYCLES-th consecutive strobe-free RUN cycle.
   assign wdog_fire = (state == RUN) && !as_wen && (wd_q == WW'(WDOG_CYCLES - 1));
`else
   assign wdog_fire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept && legal) state_nx = ISSUE;
         ISSUE: state_nx = RUN;
         RUN: begin
            if (cnt_tc) begin
               state_nx = (j_q == (k_q - 3'd1)) ? DONE : GAP;
            end else if (wdog_fire) begin
               state_nx = IDLE;
            end
         end
         GAP:   if (gap_q == GW'(GAP_CYCLES - 1)) state_nx = ISSUE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Command latch, job index, offset stepping, gap timer and illegal-command error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         add_q   <= 1'b0;
         k_q     <= '0;
         j_q     <= '0;
         off_a_q <= '0;
         off_b_q <= '0;
         gap_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept && !legal;
         if (accept) begin
            add_q   <= cmd_add;
            k_q     <= cmd_k;
            j_q     <= '0;
            off_a_q <= cmd_base_a;
            off_b_q <= cmd_base_b;
         end else if (next_job) begin
            // Offsets move only here, so they are stable from ISSUE through GAP; wrap is intended.
            j_q     <= j_q + 3'd1;
            off_a_q <= off_a_q + ADDR_W'(WORDS_PER_POLY);
            off_b_q <= off_b_q + ADDR_W'(WORDS_PER_POLY);
         end
         if (state == GAP) begin
            gap_q <= gap_q + GW'(1);
         end else begin
            gap_q <= '0;
         end
      end
   end

   assign cmd_ready   = (state == IDLE);
   assign busy        = (state == ISSUE) || (state == RUN) || (state == GAP);
   assign done        = (state == DONE);
   assign as_start    = (state == ISSUE);
   assign err         = err_q || wdog_fire;
   assign as_add_flag = add_q;
   assign as_offset_a = off_a_q;
   assign as_offset_b = off_b_q;

endmodule

// File: tb/tb_polyvec_addsub_ctrl.sv
// Purpose: scoreboard bench for polyvec_addsub_ctrl with a behavioural add/sub unit model.
// Latency: expected event cycles are derived from the command's accept cycle.
// Backpressure: commands wait on cmd_ready; every wait is cycle-bounded.
module tb_polyvec_addsub_ctrl;

   localparam int WPP  = 32;
   localparam int GAPC = 2;
   localparam int WDOG = 255;
   localparam int PER  = WPP + GAPC + 1;   // start-to-start spacing of jobs
   localparam int EV_START = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ERR   = 2;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] oa;
      logic [7:0] ob;
      logic       add;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_add;
   logic [2:0] cmd_k;
   logic [7:0] cmd_base_a, cmd_base_b;
   logic       busy, done, err, as_start, as_add_flag;
   logic [7:0] as_offset_a, as_offset_b;
   logic       as_wen;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   int  wen_per_job = WPP;
   int  rem = 0;
   ev_t sb[$];

   polyvec_addsub_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_add     (cmd_add),
      .cmd_k       (cmd_k),
      .cmd_base_a  (cmd_base_a),
      .cmd_base_b  (cmd_base_b),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .as_start    (as_start),
      .as_add_flag (as_add_flag),
      .as_offset_a (as_offset_a),
      .as_offset_b (as_offset_b),
      .as_wen      (as_wen)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Add/sub unit model: after seeing as_start, writes wen_per_job words on consecutive cycles.
   always @(negedge clk) begin
      if (rst) begin
         as_wen = 1'b0;
         rem    = 0;
      end else if (as_start) begin
         as_wen = 1'b0;
         rem    = wen_per_job;
      end else if (rem > 0) begin
         as_wen = 1'b1;
         rem    = rem - 1;
      end else begin
         as_wen = 1'b0;
      end
   end

   // Monitor: every start/done/err pulse must match the head of the scoreboard.
   always @(negedge clk) begin : monitor
      ev_t e;
      int  k;
      if (!rst && (as_start || done || err)) begin
         k = as_start ? EV_START : (done ? EV_DONE : EV_ERR);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d oa=%h ob=%h", k, cyc, as_offset_a, as_offset_b);
         end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc ||
                (k == EV_START && (e.oa != as_offset_a || e.ob != as_offset_b || e.add != as_add_flag))) begin
               errors++;
               $display("FAIL event got kind=%0d cyc=%0d oa=%h ob=%h add=%b expected kind=%0d cyc=%0d oa=%h ob=%h add=%b",
                        k, cyc, as_offset_a, as_offset_b, as_add_flag, e.kind, e.cyc, e.oa, e.ob, e.add);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Present a command (valid stays high on return), wait for accept and queue its expected events.
   task automatic send(input logic add, input logic [2:0] k, input logic [7:0] a, input logic [7:0] b);
      int  d;
      int  n;
      ev_t e;
      cmd_valid  = 1'b1;
      cmd_add    = add;
      cmd_k      = k;
      cmd_base_a = a;
      cmd_base_b = b;
      n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait_ready", int'(cmd_ready), 1);
      d = cyc;
      e.oa  = 8'h00;
      e.ob  = 8'h00;
      e.add = add;
      if (k == 3'd0 || k > 3'd4) begin
         e.kind = EV_ERR;
         e.cyc  = d + 1;
         sb.push_back(e);
      end else if (wen_per_job < WPP) begin
         e.kind = EV_START;
         e.cyc  = d + 1;
         e.oa   = a;
         e.ob   = b;
         sb.push_back(e);
         e.kind = EV_ERR;
         e.cyc  = d + 1 + wen_per_job + WDOG;
         sb.push_back(e);
      end else begin
         for (int j = 0; j < int'(k); j++) begin
            e.kind = EV_START;
            e.cyc  = d + 1 + PER * j;
            e.oa   = a + 8'(WPP * j);
            e.ob   = b + 8'(WPP * j);
            sb.push_back(e);
         end
         e.kind = EV_DONE;
         e.cyc  = d + 1 + PER * (int'(k) - 1) + WPP + 1;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(sb.size() == 0 && cmd_ready) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(sb.size() == 0 && cmd_ready), 1);
      @(negedge clk);
   endtask

   initial begin : timeout
      #200000;
      errors++;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stim
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_add    = 1'b0;
      cmd_k      = 3'd0;
      cmd_base_a = 8'h00;
      cmd_base_b = 8'h00;
      repeat (2) @(negedge clk);

      chk("rst_cmd_ready",   int'(cmd_ready), 1);
      chk("rst_busy",        int'(busy), 0);
      chk("rst_done",        int'(done), 0);
      chk("rst_err",         int'(err), 0);
      chk("rst_as_start",    int'(as_start), 0);
      chk("rst_as_add_flag", int'(as_add_flag), 0);
      chk("rst_offset_a",    int'(as_offset_a), 0);
      chk("rst_offset_b",    int'(as_offset_b), 0);
      rst = 1'b0;
      @(negedge clk);

      // Add, two polynomials.
      send(1'b1, 3'd2, 8'd32, 8'd64);
      cmd_valid = 1'b0;
      chk("k2_busy", int'(busy), 1);
      wait_idle("k2_complete");

      // Subtract, four polynomials, A offsets wrap past 0xFF.
      send(1'b0, 3'd4, 8'hF0, 8'h80);
      cmd_valid = 1'b0;
      wait_idle("k4_complete");

      // Illegal counts back to back: err each, no start, ready stays high.
      send(1'b1, 3'd0, 8'h11, 8'h22);
      chk("k0_ready", int'(cmd_ready), 1);
      send(1'b1, 3'd5, 8'h33, 8'h44);
      cmd_valid = 1'b0;
      chk("k5_ready", int'(cmd_ready), 1);
      wait_idle("illegal_complete");

      // Valid held through busy: second accept exactly the cycle after done.
      send(1'b1, 3'd1, 8'h10, 8'h20);
      send(1'b0, 3'd1, 8'h40, 8'h60);
      cmd_valid = 1'b0;
      wait_idle("b2b_complete");

      // Reset during RUN of the second job: abandon silently.
      send(1'b1, 3'd2, 8'h00, 8'h40);
      cmd_valid = 1'b0;
      repeat (PER + 10) @(negedge clk);
      chk("midrun_busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_rst_ready", int'(cmd_ready), 1);
      chk("midrun_rst_busy",  int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_pending_done", sb.size(), 1);
      sb.delete();
      repeat (60) @(negedge clk);

`ifdef ADDSUB_WATCHDOG_EN
      // Unit stalls after 10 writes: err WDOG cycles after the last write, no done.
      wen_per_job = 10;
      send(1'b1, 3'd1, 8'h20, 8'h30);
      cmd_valid = 1'b0;
      wait_idle("wdog_complete");
      chk("wdog_ready", int'(cmd_ready), 1);
      chk("wdog_busy",  int'(busy), 0);
      wen_per_job = WPP;
`endif

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/polyvec_addsub_ctrl.md
Name: polyvec_addsub_ctrl

Overview:
- Command-level sequencer for the polynomial add/sub unit.
- Accepts one vector operation (K polynomials, add or subtract) and issues K back-to-back per-polynomial jobs to the add/sub unit, with A/B base offsets advanced by one polynomial stride per job.
- Counts the unit's RAM write strobes to detect the end of each polynomial, then signals command completion.
- Sits between the Kyber top-level control FSM and the add/sub datapath that shares the 96-bit coefficient RAM.

Parameters:
- ADDR_W, 8, RAM word-address width.
- WORDS_PER_POLY, 32, RAM words per polynomial: 256 coeffs / 8 coeffs per 96-bit word.
- K_MAX, 4, maximum polynomials per vector (Kyber-1024).
- GAP_CYCLES, 2, idle cycles between one job's last write and the next job's start.
- WDOG_CYCLES, 255, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_add  in  1  1 = add, 0 = subtract.
- cmd_k  in  3  polynomial count; legal values 1..K_MAX.
- cmd_base_a  in  ADDR_W  word address of polynomial A[0].
- cmd_base_b  in  ADDR_W  word address of polynomial B[0].
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  one-cycle pulse when an illegal command is rejected, or on watchdog expiry.
- as_start  out  1  one-cycle start pulse to the add/sub unit.
- as_add_flag  out  1  add/sub select to the unit; held for the whole command.
- as_offset_a  out  ADDR_W  A offset for the current job.
- as_offset_b  out  ADDR_W  B offset for the current job.
- as_wen  in  1  the unit's RAM write strobe, monitored.

Behaviour:
- Reset (rst high at a clock edge): state IDLE. cmd_ready=1. busy, done, err, as_start, as_add_flag = 0. as_offset_a, as_offset_b = 0. All counters 0.
- rst takes priority in every state; reset mid-command abandons the job silently (no done, no err).
- Handshake: a command is accepted on any edge with cmd_valid & cmd_ready. cmd_ready = (state==IDLE).
- Accepting a command latches cmd_add, cmd_k, cmd_base_a and cmd_base_b.
- Illegal cmd_k (0 or >K_MAX): the command is accepted, err pulses on the next cycle, state stays IDLE, and no as_start is issued.
- States:
  - IDLE: on a legal accept -> ISSUE. Set busy=1, job index j=0, offsets = latched bases.
  - ISSUE: assert as_start for exactly 1 cycle, clear the write counter -> RUN.
  - RUN: count as_wen pulses. An as_wen coinciding with the ISSUE cycle is ignored. When the count reaches WORDS_PER_POLY: if j==k-1 -> DONE, else -> GAP.
  - GAP: hold for GAP_CYCLES. Then j+=1, offsets += WORDS_PER_POLY -> ISSUE.
  - DONE: done=1 and busy=0 for 1 cycle -> IDLE. cmd_ready rises in the same cycle the state returns to IDLE.
- Latency: as_start is high the cycle after accept.
- Offsets are stable from ISSUE through GAP of each job and change only on the GAP->ISSUE transition.
- Address arithmetic is modulo 2^ADDR_W: the base plus j*WORDS_PER_POLY wraps silently (e.g. base 0xF0, j=1 -> 0x10).
- as_wen in IDLE or DONE is ignored; no error is raised.
- Extra as_wen pulses beyond WORDS_PER_POLY within a job are impossible by construction, since the state leaves RUN on the count.
- Write counter width: clog2(WORDS_PER_POLY)+1 bits.

Optional Feature:
- Macro: ADDSUB_WATCHDOG_EN.
- Defined: in RUN, a counter reloads on each as_wen. If WDOG_CYCLES cycles pass with no as_wen, err pulses for 1 cycle, done is not asserted, and the state returns to IDLE.
- Undefined: no watchdog logic; RUN waits indefinitely.

Decomposition:
- Shared package kyber_pkg holds:
  - COEF_W=12, COEFS_PER_WORD=8, WORD_W=96, ADDR_W=8, WORDS_PER_POLY=32, K_MAX=4.
  - State enum: IDLE, ISSUE, RUN, GAP, DONE.
- One sub-module, wen_counter: counts strobes, provides a terminal-count flag and clears synchronously.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0 except cmd_ready=1. Assert rst during RUN of job 1 -> IDLE next cycle, no done.
- Add, k=2, base_a=32, base_b=64, unit model emits 32 as_wen per job -> as_start one cycle after accept, then again with offsets 64/96 after 32 writes plus GAP_CYCLES; done 1 cycle after the 64th write; as_add_flag=1 throughout.
- Subtract, k=4, base_a=0xF0, base_b=0x80 -> offset_a sequence F0,10,30,50 and offset_b sequence 80,A0,C0,E0; 4 as_start pulses; as_add_flag=0.
- cmd_k=0, then cmd_k=5 -> err pulse each, no as_start, cmd_ready stays 1.
- cmd_valid held high during busy -> no second accept until the cycle after done; back-to-back commands are accepted with zero idle gap.
- With ADDSUB_WATCHDOG_EN defined and the unit model stalling after 10 writes -> err exactly WDOG_CYCLES cycles after the last write, no done, cmd_ready=1.
